// File: rtl/traffic_lamp_driver_if.sv
// traffic_lamp_driver_if
//   Bundles the light-code inputs, the fault-clear request and all lamp /
//   fault outputs of traffic_lamp_driver.
//   master : upstream sequencer / software side (drives codes and clr_fault)
//   slave  : traffic_lamp_driver (drives lamps, fault, fault_code)
//   Optional: FAULT_CNT_EN adds the 8-bit fault_count output.
interface traffic_lamp_driver_if;
  logic [1:0] highway;
  logic [1:0] street;
  logic       clr_fault;
  logic       hw_red, hw_yellow, hw_green;
  logic       st_red, st_yellow, st_green;
  logic       fault;
  logic [1:0] fault_code;
`ifdef FAULT_CNT_EN
  logic [7:0] fault_count;
`endif

  modport master (
    output highway, street, clr_fault,
    input  hw_red, hw_yellow, hw_green, st_red, st_yellow, st_green,
    input  fault, fault_code
`ifdef FAULT_CNT_EN
    , input fault_count
`endif
  );

  modport slave (
    input  highway, street, clr_fault,
    output hw_red, hw_yellow, hw_green, st_red, st_yellow, st_green,
    output fault, fault_code
`ifdef FAULT_CNT_EN
    , output fault_count
`endif
  );
endinterface

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver
//   Lamp driver and safety monitor behind the traffic-light sequencer.
//   Registers the 2-bit highway/street codes, checks them for conflicting
//   greens, invalid codes and illegal colour steps, and drives six lamps.
//   Any violation latches a fault and flashes both reds until clr_fault is
//   accepted; lamps then come back through an all-red recovery interval.
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-high reset
//   lamp_if  : traffic_lamp_driver_if.slave
//              in  highway[1:0], street[1:0], clr_fault
//              out hw_red/yellow/green, st_red/yellow/green,
//                  fault, fault_code[1:0] (01 conflict, 10 invalid, 11 sequence)
// Parameters
//   BLINK_DIV      : cycles per half-period of the fault flash (>=2)
//   ALL_RED_CYCLES : cycles of steady all-red recovery (>=1)
// Optional build macro
//   FAULT_CNT_EN   : adds fault_count[7:0], a saturating count of fault entries
module traffic_lamp_driver #(
  parameter int BLINK_DIV      = 8,
  parameter int ALL_RED_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  traffic_lamp_driver_if.slave lamp_if
);

  localparam int RW = (ALL_RED_CYCLES > 1) ? $clog2(ALL_RED_CYCLES) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REC_LAST   = RW'(ALL_RED_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_GRN = 2'b01;
  localparam logic [1:0] C_YEL = 2'b10;
  localparam logic [1:0] C_INV = 2'b11;

  localparam logic [1:0] F_NONE     = 2'b00;
  localparam logic [1:0] F_CONFLICT = 2'b01;
  localparam logic [1:0] F_INVALID  = 2'b10;
  localparam logic [1:0] F_SEQUENCE = 2'b11;

  typedef enum logic [1:0] {
    S_RECOVER = 2'd0,
    S_NORMAL  = 2'd1,
    S_FAULT   = 2'd2
  } state_e;

  typedef struct packed {
    logic hw_r, hw_y, hw_g;
    logic st_r, st_y, st_g;
  } lamps_t;

  localparam lamps_t ALL_RED = lamps_t'(6'b100_100);

  // one-hot {red, yellow, green} for a legal colour code
  function automatic logic [2:0] decode(input logic [1:0] c);
    decode = {c == C_RED, c == C_YEL, c == C_GRN};
  endfunction

  // only G->Y, Y->R, R->G and "unchanged" are legal steps
  function automatic logic seq_bad(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      {C_GRN, C_RED},
      {C_RED, C_YEL},
      {C_YEL, C_GRN}: seq_bad = 1'b1;
      default:        seq_bad = 1'b0;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [RW-1:0] rec_cnt_q, rec_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    hw_q, st_q;
  logic [1:0]    prev_hw_q, prev_hw_d;
  logic [1:0]    prev_st_q, prev_st_d;
  logic          prev_valid_q, prev_valid_d;
  lamps_t        lamps_q, lamps_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_code_q, fault_code_d;

  logic          conflict, invalid, seq_err;
  logic [1:0]    hard_cause;
  logic          enter_fault;
  logic [1:0]    new_cause;
  logic          flash_red;

  // ---------------- checks on the registered codes ----------------
  always_comb begin
    conflict   = (hw_q != C_RED) && (st_q != C_RED);
    invalid    = (hw_q == C_INV) || (st_q == C_INV);
    seq_err    = prev_valid_q &&
                 (seq_bad(prev_hw_q, hw_q) || seq_bad(prev_st_q, st_q));
    hard_cause = conflict ? F_CONFLICT : (invalid ? F_INVALID : F_NONE);
  end

  // ---------------- next-state / lamp logic ----------------
  // Lamps are computed from the state being entered on this edge, so a
  // pattern that trips a check is replaced by red before it is ever shown.
  always_comb begin
    state_d      = state_q;
    rec_cnt_d    = rec_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    prev_hw_d    = prev_hw_q;
    prev_st_d    = prev_st_q;
    prev_valid_d = 1'b0;          // history is only trusted while in NORMAL
    lamps_d      = ALL_RED;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    enter_fault  = 1'b0;
    new_cause    = F_NONE;
    flash_red    = lamps_q.hw_r;

    case (state_q)
      S_RECOVER: begin
        if (conflict || invalid) begin
          enter_fault = 1'b1;
          new_cause   = hard_cause;
        end else if (rec_cnt_q == REC_LAST) begin
          state_d      = S_NORMAL;
          rec_cnt_d    = '0;
          fault_d      = 1'b0;
          fault_code_d = F_NONE;
          lamps_d      = lamps_t'({decode(hw_q), decode(st_q)});
        end else begin
          rec_cnt_d = rec_cnt_q + RW'(1);
        end
      end

      S_NORMAL: begin
        if (conflict || invalid || seq_err) begin
          enter_fault = 1'b1;
          new_cause   = (hard_cause != F_NONE) ? hard_cause : F_SEQUENCE;
        end else begin
          lamps_d      = lamps_t'({decode(hw_q), decode(st_q)});
          prev_hw_d    = hw_q;
          prev_st_d    = st_q;
          prev_valid_d = 1'b1;
        end
      end

      S_FAULT: begin
        // a clear is only honoured once the inputs are safe again
        if (lamp_if.clr_fault && !conflict && !invalid) begin
          state_d     = S_RECOVER;
          rec_cnt_d   = '0;
          blink_cnt_d = '0;
          lamps_d     = ALL_RED;
        end else begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            flash_red   = ~lamps_q.hw_r;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
          lamps_d = lamps_t'({flash_red, 2'b00, flash_red, 2'b00});
        end
      end

      default: begin
        state_d   = S_RECOVER;
        rec_cnt_d = '0;
      end
    endcase

    if (enter_fault) begin
      state_d      = S_FAULT;
      rec_cnt_d    = '0;
      blink_cnt_d  = '0;
      fault_d      = 1'b1;
      fault_code_d = new_cause;
      lamps_d      = ALL_RED;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RECOVER;
      rec_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      hw_q         <= C_RED;
      st_q         <= C_RED;
      prev_hw_q    <= C_RED;
      prev_st_q    <= C_RED;
      prev_valid_q <= 1'b0;
      lamps_q      <= ALL_RED;
      fault_q      <= 1'b0;
      fault_code_q <= F_NONE;
    end else begin
      state_q      <= state_d;
      rec_cnt_q    <= rec_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      hw_q         <= lamp_if.highway;
      st_q         <= lamp_if.street;
      prev_hw_q    <= prev_hw_d;
      prev_st_q    <= prev_st_d;
      prev_valid_q <= prev_valid_d;
      lamps_q      <= lamps_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

`ifdef FAULT_CNT_EN
  // counts entries only; re-detection while already flashing is not an entry
  logic [7:0] fault_count_q, fault_count_d;

  always_comb begin
    fault_count_d = fault_count_q;
    if (enter_fault && (fault_count_q != 8'hFF))
      fault_count_d = fault_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_count_q <= '0;
    else     fault_count_q <= fault_count_d;
  end

  assign lamp_if.fault_count = fault_count_q;
`endif

  assign lamp_if.hw_red     = lamps_q.hw_r;
  assign lamp_if.hw_yellow  = lamps_q.hw_y;
  assign lamp_if.hw_green   = lamps_q.hw_g;
  assign lamp_if.st_red     = lamps_q.st_r;
  assign lamp_if.st_yellow  = lamps_q.st_y;
  assign lamp_if.st_green   = lamps_q.st_g;
  assign lamp_if.fault      = fault_q;
  assign lamp_if.fault_code = fault_code_q;

endmodule
